fetch_unit: RTL and testbench



---
 rtl/fetch_unit.sv | 157 +++++++++++++++
 tb/tb_fetch_unit.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// LEGv8 multi-cycle fetch front end: PC, instruction register, imem handshake.
// Optional fetch watchdog enabled by defining FETCH_TIMEOUT_EN.
module fetch_unit #(
   parameter logic [63:0] PC_RESET  = 64'h0,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
   parameter int unsigned TIMEOUT   = 16
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        il,
   input  logic [1:0]  ps,
   input  logic [63:0] k,
   input  logic [63:0] reg_a,
   output logic [63:0] imem_addr,
   output logic        imem_req,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instruction,
   output logic [63:0] pc,
   output logic [63:0] ipc,
   output logic        fetch_busy,
   output logic        instr_valid
`ifdef FETCH_TIMEOUT_EN
   ,
   output logic        fetch_err
`endif
);

   typedef enum logic {
      S_IDLE,
      S_WAIT
   } state_t;

   state_t      state_q, state_d;
   logic [63:0] pc_q, pc_d;
   logic [63:0] ipc_q, ipc_d;
   logic [63:0] addr_q, addr_d;
   logic [31:0] instr_q, instr_d;
   logic        req_q, req_d;
   logic        busy_q, busy_d;
   logic        valid_q, valid_d;
   logic [63:0] br_off;

`ifdef FETCH_TIMEOUT_EN
   localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
   logic [CW-1:0] cnt_q, cnt_d;
   logic          err_q, err_d;
`endif

   // B/BL carry a 26-bit offset; B.cond/CBZ/CBNZ carry a 19-bit one
   assign br_off = (instr_q[30:29] == 2'b00)
                 ? {{36{k[25]}}, k[25:0], 2'b00}
                 : {{43{k[18]}}, k[18:0], 2'b00};

   logic unused_k;
   assign unused_k = ^k[63:26];

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ipc_d   = ipc_q;
      addr_d  = addr_q;
      instr_d = instr_q;
      req_d   = req_q;
      busy_d  = busy_q;
      valid_d = 1'b0;
`ifdef FETCH_TIMEOUT_EN
      cnt_d   = cnt_q;
      err_d   = err_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (il) begin
               addr_d  = pc_q;
               ipc_d   = pc_q;
               req_d   = 1'b1;
               busy_d  = 1'b1;
               state_d = S_WAIT;
`ifdef FETCH_TIMEOUT_EN
               cnt_d   = '0;
`endif
            end
            case (ps)
               2'b01:   pc_d = pc_q + 64'd4;
               2'b10:   pc_d = ipc_q + br_off;
               2'b11:   pc_d = reg_a;
               default: pc_d = pc_q;
            endcase
         end
         S_WAIT: begin
            if (imem_ack) begin
               instr_d = imem_rdata;
               req_d   = 1'b0;
               busy_d  = 1'b0;
               valid_d = 1'b1;
               state_d = S_IDLE;
            end
`ifdef FETCH_TIMEOUT_EN
            else if (cnt_q == CNT_LAST) begin
               instr_d = NOP_INSTR;
               req_d   = 1'b0;
               busy_d  = 1'b0;
               valid_d = 1'b1;
               err_d   = 1'b1;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         pc_q    <= PC_RESET;
         ipc_q   <= PC_RESET;
         addr_q  <= '0;
         instr_q <= NOP_INSTR;
         req_q   <= 1'b0;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
         cnt_q   <= '0;
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ipc_q   <= ipc_d;
         addr_q  <= addr_d;
         instr_q <= instr_d;
         req_q   <= req_d;
         busy_q  <= busy_d;
         valid_q <= valid_d;
`ifdef FETCH_TIMEOUT_EN
         cnt_q   <= cnt_d;
         err_q   <= err_d;
`endif
      end
   end

   assign imem_addr   = addr_q;
   assign imem_req    = req_q;
   assign instruction = instr_q;
   assign pc          = pc_q;
   assign ipc         = ipc_q;
   assign fetch_busy  = busy_q;
   assign instr_valid = valid_q;
`ifdef FETCH_TIMEOUT_EN
   assign fetch_err   = err_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: handshake, PC select, branch sizing, reset.
module tb_fetch_unit;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        il;
   logic [1:0]  ps;
   logic [63:0] k;
   logic [63:0] reg_a;
   logic [63:0] imem_addr;
   logic        imem_req;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instruction;
   logic [63:0] pc;
   logic [63:0] ipc;
   logic        fetch_busy;
   logic        instr_valid;
`ifdef FETCH_TIMEOUT_EN
   logic        fetch_err;
`endif

   int n_cmp = 0;
   int n_err = 0;

   fetch_unit #(
      .PC_RESET (64'h100),
      .NOP_INSTR(32'h0000_0000),
      .TIMEOUT  (4)
   ) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .il         (il),
      .ps         (ps),
      .k          (k),
      .reg_a      (reg_a),
      .imem_addr  (imem_addr),
      .imem_req   (imem_req),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .instruction(instruction),
      .pc         (pc),
      .ipc        (ipc),
      .fetch_busy (fetch_busy),
      .instr_valid(instr_valid)
`ifdef FETCH_TIMEOUT_EN
      ,
      .fetch_err  (fetch_err)
`endif
   );

   always #5 clock = ~clock;

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      reset_n    = 1'b0;
      il         = 1'b0;
      ps         = 2'b00;
      k          = '0;
      reg_a      = '0;
      imem_ack   = 1'b0;
      imem_rdata = '0;
      tick;
      tick;
      chk("rst_pc", pc, 64'h100);
      chk("rst_ipc", ipc, 64'h100);
      chk("rst_instr", instruction, 64'h0);
      chk("rst_req", imem_req, 64'h0);
      chk("rst_addr", imem_addr, 64'h0);
      chk("rst_busy", fetch_busy, 64'h0);
      chk("rst_valid", instr_valid, 64'h0);
      reset_n = 1'b1;

      // fetch with PC+4, ack two cycles after il
      il = 1'b1;
      ps = 2'b01;
      tick;
      il = 1'b0;
      ps = 2'b00;
      chk("f1_addr", imem_addr, 64'h100);
      chk("f1_req", imem_req, 64'h1);
      chk("f1_busy", fetch_busy, 64'h1);
      chk("f1_pc", pc, 64'h104);
      chk("f1_ipc", ipc, 64'h100);
      tick;
      chk("f1_req_hold", imem_req, 64'h1);
      chk("f1_novalid", instr_valid, 64'h0);
      imem_ack   = 1'b1;
      imem_rdata = 32'h8B02_0020;
      tick;
      imem_ack = 1'b0;
      chk("f1_instr", instruction, 64'h8B02_0020);
      chk("f1_valid", instr_valid, 64'h1);
      chk("f1_req_drop", imem_req, 64'h0);
      chk("f1_busy_drop", fetch_busy, 64'h0);
      chk("f1_pc_after", pc, 64'h104);
      tick;
      chk("f1_valid_pulse", instr_valid, 64'h0);

      // B with 26-bit negative offset from ipc=0x200
      ps    = 2'b11;
      reg_a = 64'h200;
      tick;
      ps = 2'b00;
      chk("jmp_200", pc, 64'h200);
      il = 1'b1;
      tick;
      il         = 1'b0;
      imem_ack   = 1'b1;
      imem_rdata = 32'h1400_0000;
      tick;
      imem_ack = 1'b0;
      chk("b_ipc", ipc, 64'h200);
      ps = 2'b10;
      k  = 64'h3FF_FFFE;
      tick;
      ps = 2'b00;
      chk("b_neg", pc, 64'h1F8);

      // B.cond: only k[18:0] counts, bit 19 must be ignored
      ps    = 2'b11;
      reg_a = 64'h200;
      tick;
      il = 1'b1;
      ps = 2'b00;
      tick;
      il         = 1'b0;
      imem_ack   = 1'b1;
      imem_rdata = 32'h5400_0080;
      tick;
      imem_ack = 1'b0;
      ps = 2'b10;
      k  = 64'h8_0004;
      tick;
      ps = 2'b00;
      chk("bcond_pos", pc, 64'h210);

      // PC+4 wraps at 2^64
      ps    = 2'b11;
      reg_a = 64'hFFFF_FFFF_FFFF_FFFC;
      tick;
      ps = 2'b01;
      tick;
      ps = 2'b00;
      chk("pc_wrap", pc, 64'h0);

      // BR, then ps ignored while busy; il in WAIT ignored; ack withheld
      ps    = 2'b11;
      reg_a = 64'hDEAD_BEE0;
      tick;
      ps = 2'b00;
      chk("br_pc", pc, 64'hDEAD_BEE0);
      il = 1'b1;
      tick;
      chk("br_addr", imem_addr, 64'hDEAD_BEE0);
      ps    = 2'b11;
      reg_a = 64'h1234_5678;
      for (int i = 0; i < 5; i++) begin
         tick;
         il = 1'b0;
         chk("wait_req", imem_req, 64'h1);
         chk("wait_addr", imem_addr, 64'hDEAD_BEE0);
         chk("wait_pc", pc, 64'hDEAD_BEE0);
      end
      ps         = 2'b00;
      imem_ack   = 1'b1;
      imem_rdata = 32'hAAAA_5555;
      tick;
      imem_ack = 1'b0;
      chk("late_instr", instruction, 64'hAAAA_5555);
      chk("late_ipc", ipc, 64'hDEAD_BEE0);
      chk("late_valid", instr_valid, 64'h1);

      // stray ack in IDLE
      imem_ack   = 1'b1;
      imem_rdata = 32'h1111_1111;
      tick;
      imem_ack = 1'b0;
      chk("stray_instr", instruction, 64'hAAAA_5555);
      chk("stray_valid", instr_valid, 64'h0);
      chk("stray_req", imem_req, 64'h0);

      // il together with BR: fetch old pc, pc takes reg_a
      il    = 1'b1;
      ps    = 2'b11;
      reg_a = 64'h300;
      tick;
      il = 1'b0;
      ps = 2'b00;
      chk("ilbr_addr", imem_addr, 64'hDEAD_BEE0);
      chk("ilbr_pc", pc, 64'h300);
      imem_ack   = 1'b1;
      imem_rdata = 32'hAAAA_5555;
      tick;
      imem_ack = 1'b0;
      chk("ilbr_valid", instr_valid, 64'h1);

`ifdef FETCH_TIMEOUT_EN
      il = 1'b1;
      tick;
      il = 1'b0;
      for (int i = 0; i < 3; i++) tick;
      chk("to_req_hold", imem_req, 64'h1);
      tick;
      chk("to_req", imem_req, 64'h0);
      chk("to_instr", instruction, 64'h0);
      chk("to_err", fetch_err, 64'h1);
      chk("to_valid", instr_valid, 64'h1);
      tick;
      chk("to_err_sticky", fetch_err, 64'h1);
      chk("to_valid_pulse", instr_valid, 64'h0);
`endif

      // reset during WAIT, then a late ack
      il = 1'b1;
      tick;
      il = 1'b0;
      chk("rw_req", imem_req, 64'h1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("rw_req_drop", imem_req, 64'h0);
      chk("rw_busy", fetch_busy, 64'h0);
      chk("rw_pc", pc, 64'h100);
`ifdef FETCH_TIMEOUT_EN
      chk("rw_err", fetch_err, 64'h0);
`endif
      tick;
      reset_n    = 1'b1;
      imem_ack   = 1'b1;
      imem_rdata = 32'hCAFE_F00D;
      tick;
      imem_ack = 1'b0;
      chk("rw_instr", instruction, 64'h0);
      chk("rw_valid", instr_valid, 64'h0);
      chk("rw_req_idle", imem_req, 64'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
